// File: rtl/mem_access_stage_pkg.sv
// Shared MEM-stage definitions: FSM states, byte-enable constants, control-bit
// positions agreed with Decode/Execute, and the bundles the stage registers.
package mem_access_stage_pkg;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_REQ  = 1'b1
  } mem_state_e;

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_BYTE0 = 4'b1000;

  // Bit positions of the memory controls inside the pipeline control word
  localparam int CTL_MEM_RD       = 0;
  localparam int CTL_MEM_WR       = 1;
  localparam int CTL_MEM_BYTE     = 2;
  localparam int CTL_MEM_UNSIGNED = 3;
  localparam int CTL_WIDTH        = 4;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_cmd_t;

  typedef struct packed {
    logic [4:0] dest;
    logic       reg_wr;
    logic       is_load;
    logic       byte_acc;
    logic       is_unsigned;
    logic [1:0] offset;
  } mem_ctx_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [4:0]  dest;
    logic        reg_wr;
  } wb_bundle_t;

  // Big-endian lanes: byte offset 0 is the MSB lane
  function automatic logic [3:0] byte_lane_be(input logic [1:0] offset);
    return BE_BYTE0 >> offset;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage and the memory.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage_load_align.sv
// Big-endian load extraction: picks the addressed byte lane and sign/zero
// extends it, or passes a full word through.
module mem_access_stage_load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic        byte_sel,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0] lane;

  always_comb begin
    case (offset)
      2'd0:    lane = rdata[31:24];
      2'd1:    lane = rdata[23:16];
      2'd2:    lane = rdata[15:8];
      default: lane = rdata[7:0];
    endcase

    if (!byte_sel)        result = rdata;
    else if (is_unsigned) result = {24'h000000, lane};
    else                  result = {{24{lane[7]}}, lane};
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory accesses with big-endian lane
// handling, stalls upstream while one is outstanding, registers writeback.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               valid_mem,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        store_data,
  input  logic               mem_rd,
  input  logic               mem_wr,
  input  logic               mem_byte,
  input  logic               mem_unsigned,
  input  logic               reg_wr,
  input  logic [4:0]         dest,
  output logic               stall,
  mem_access_stage_if.master dmem,
  output logic               wb_valid,
  output logic [31:0]        wb_data,
  output logic [4:0]         wb_dest,
  output logic               wb_reg_wr,
  output logic               misalign,
  output logic               bus_error
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  mem_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  dmem_cmd_t            cmd_q, cmd_d;
  mem_ctx_t             ctx_q, ctx_d;
  wb_bundle_t           wb_q, wb_d;
  logic                 misalign_q, misalign_d;
  logic                 bus_error_q, bus_error_d;

  logic [CTL_WIDTH-1:0] ctl;
  logic                 memop;
  logic                 misaligned;
  logic                 timeout_hit;
  logic [31:0]          load_data;

  always_comb begin
    ctl                   = '0;
    ctl[CTL_MEM_RD]       = mem_rd;
    ctl[CTL_MEM_WR]       = mem_wr;
    ctl[CTL_MEM_BYTE]     = mem_byte;
    ctl[CTL_MEM_UNSIGNED] = mem_unsigned;
  end

  assign memop       = valid_mem & (ctl[CTL_MEM_RD] | ctl[CTL_MEM_WR]);
  assign misaligned  = !ctl[CTL_MEM_BYTE] & (alu_result[1:0] != 2'b00);
  assign timeout_hit = (cnt_q == CNT_LAST);

  mem_access_stage_load_align u_load_align (
    .rdata       (dmem.dmem_rdata),
    .offset      (ctx_q.offset),
    .byte_sel    (ctx_q.byte_acc),
    .is_unsigned (ctx_q.is_unsigned),
    .result      (load_data)
  );

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    ctx_d       = ctx_q;
    wb_d        = wb_q;
    wb_d.valid  = 1'b0;
    misalign_d  = 1'b0;
    bus_error_d = 1'b0;
    stall       = 1'b0;

    case (state_q)
      MEM_IDLE: begin
        if (valid_mem && !memop) begin
          wb_d.valid  = 1'b1;
          wb_d.data   = alu_result;
          wb_d.dest   = dest;
          wb_d.reg_wr = reg_wr;
        end else if (memop && misaligned) begin
          misalign_d = 1'b1;
        end else if (memop) begin
          stall      = 1'b1;
          cmd_d.req  = 1'b1;
          cmd_d.we   = ctl[CTL_MEM_WR] & !ctl[CTL_MEM_RD];
          cmd_d.addr = {alu_result[31:2], 2'b00};
          if (ctl[CTL_MEM_BYTE]) begin
            cmd_d.wdata = {4{store_data[7:0]}};
            cmd_d.be    = byte_lane_be(alu_result[1:0]);
          end else begin
            cmd_d.wdata = store_data;
            cmd_d.be    = BE_WORD;
          end
          ctx_d.dest        = dest;
          ctx_d.reg_wr      = reg_wr;
          ctx_d.is_load     = ctl[CTL_MEM_RD];
          ctx_d.byte_acc    = ctl[CTL_MEM_BYTE];
          ctx_d.is_unsigned = ctl[CTL_MEM_UNSIGNED];
          ctx_d.offset      = alu_result[1:0];
          cnt_d             = '0;
          state_d           = MEM_REQ;
        end
      end

      MEM_REQ: begin
        if (dmem.dmem_ack) begin
          cmd_d.req  = 1'b0;
          state_d    = MEM_IDLE;
          wb_d.valid = 1'b1;
          wb_d.dest  = ctx_q.dest;
          if (ctx_q.is_load) begin
            wb_d.data   = load_data;
            wb_d.reg_wr = ctx_q.reg_wr;
          end else begin
            wb_d.data   = 32'h0;
            wb_d.reg_wr = 1'b0;
          end
        end else if (timeout_hit) begin
          // Abandon the access; upstream is released in this same cycle
          cmd_d.req   = 1'b0;
          bus_error_d = 1'b1;
          state_d     = MEM_IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (reset) begin
      state_q     <= MEM_IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      ctx_q       <= '0;
      wb_q        <= '0;
      misalign_q  <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      ctx_q       <= ctx_d;
      wb_q        <= wb_d;
      misalign_q  <= misalign_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign dmem.dmem_req   = cmd_q.req;
  assign dmem.dmem_we    = cmd_q.we;
  assign dmem.dmem_addr  = cmd_q.addr;
  assign dmem.dmem_wdata = cmd_q.wdata;
  assign dmem.dmem_be    = cmd_q.be;

  assign wb_valid  = wb_q.valid;
  assign wb_data   = wb_q.data;
  assign wb_dest   = wb_q.dest;
  assign wb_reg_wr = wb_q.reg_wr;
  assign misalign  = misalign_q;
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, loads, stores,
// misalignment, timeout and reset during an outstanding access.
module tb_mem_access_stage;

  logic        clock;
  logic        reset;
  logic        valid_mem;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_rd, mem_wr, mem_byte, mem_unsigned, reg_wr;
  logic [4:0]  dest;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;
  logic        wb_reg_wr;
  logic        misalign;
  logic        bus_error;

  int checks = 0;
  int errors = 0;

  mem_access_stage_if dmem_bus ();

  mem_access_stage #(
    .TIMEOUT_CYCLES (4),
    .CNT_WIDTH      (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .valid_mem    (valid_mem),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_byte     (mem_byte),
    .mem_unsigned (mem_unsigned),
    .reg_wr       (reg_wr),
    .dest         (dest),
    .stall        (stall),
    .dmem         (dmem_bus),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_dest      (wb_dest),
    .wb_reg_wr    (wb_reg_wr),
    .misalign     (misalign),
    .bus_error    (bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    valid_mem    = 1'b0;
    alu_result   = 32'h0;
    store_data   = 32'h0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_byte     = 1'b0;
    mem_unsigned = 1'b0;
    reg_wr       = 1'b0;
    dest         = 5'd0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic byt, input logic uns,
                       input logic rw, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] d);
    valid_mem    = 1'b1;
    mem_rd       = rd;
    mem_wr       = wr;
    mem_byte     = byt;
    mem_unsigned = uns;
    reg_wr       = rw;
    alu_result   = addr;
    store_data   = sdata;
    dest         = d;
  endtask

  // Memory access acknowledged in its first request cycle with the given read data
  task automatic run_quick_access(input logic [31:0] rdata);
    tick();
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = rdata;
    tick();
    dmem_bus.dmem_ack = 1'b0;
    clear_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", dmem_bus.dmem_req); end
    checks++; if (dmem_bus.dmem_be !== 4'h0) begin errors++; $display("FAIL reset_be: got %h want 0", dmem_bus.dmem_be); end
    checks++; if (dmem_bus.dmem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", dmem_bus.dmem_addr); end
    checks++; if ({wb_valid, wb_reg_wr, misalign, bus_error} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {wb_valid, wb_reg_wr, misalign, bus_error}); end
    checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
    reset = 1'b0;
  endtask

  task automatic test_alu_passthrough();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0007, 32'h0, 5'd5);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %0b want 0", stall); end
    tick();
    clear_inputs();
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL alu_wb_valid: got %0b want 1", wb_valid); end
    checks++; if (wb_data !== 32'h7) begin errors++; $display("FAIL alu_wb_data: got %h want 00000007", wb_data); end
    checks++; if (wb_dest !== 5'd5 || wb_reg_wr !== 1'b1) begin errors++; $display("FAIL alu_wb_dest: got %0d/%0b want 5/1", wb_dest, wb_reg_wr); end
    tick();
    checks++; if (wb_valid !== 1'b0 || wb_data !== 32'h7) begin errors++; $display("FAIL alu_idle_hold: got valid %0b data %h want 0/00000007", wb_valid, wb_data); end
  endtask

  task automatic test_load_word();
    int stall_cycles = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0104, 32'h0, 5'd8);
    #1;
    if (stall === 1'b1) stall_cycles++;
    tick();
    checks++; if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_we !== 1'b0) begin errors++; $display("FAIL lw_req: got req %0b we %0b want 1/0", dmem_bus.dmem_req, dmem_bus.dmem_we); end
    checks++; if (dmem_bus.dmem_addr !== 32'h104 || dmem_bus.dmem_be !== 4'b1111) begin errors++; $display("FAIL lw_addr_be: got %h/%b want 00000104/1111", dmem_bus.dmem_addr, dmem_bus.dmem_be); end
    for (int i = 1; i <= 3; i++) begin
      if (stall === 1'b1) stall_cycles++;
      checks++; if (dmem_bus.dmem_req !== 1'b1) begin errors++; $display("FAIL lw_req_hold: cycle %0d got %0b want 1", i, dmem_bus.dmem_req); end
      tick();
    end
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw_stall_on_ack: got %0b want 0", stall); end
    checks++; if (stall_cycles !== 4) begin errors++; $display("FAIL lw_stall_cycles: got %0d want 4", stall_cycles); end
    tick();
    dmem_bus.dmem_ack = 1'b0;
    clear_inputs();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_wb: got %0b/%h want 1/deadbeef", wb_valid, wb_data); end
    checks++; if (wb_dest !== 5'd8 || wb_reg_wr !== 1'b1 || dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL lw_wb_ctl: got dest %0d rw %0b req %0b want 8/1/0", wb_dest, wb_reg_wr, dmem_bus.dmem_req); end
  endtask

  task automatic test_byte_loads();
    logic [31:0] addr_v  [5] = '{32'h103, 32'h103, 32'h101, 32'h100, 32'h102};
    logic        uns_v   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] rdata_v [5] = '{32'h1122_33F0, 32'h1122_33F0, 32'h1122_33F0, 32'h8000_0000, 32'h00A5_9C00};
    logic [31:0] exp_v   [5] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'h0000_0022, 32'hFFFF_FF80, 32'h0000_009C};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, uns_v[i], 1'b1, addr_v[i], 32'h0, 5'd3);
      run_quick_access(rdata_v[i]);
      checks++; if (wb_valid !== 1'b1 || wb_data !== exp_v[i]) begin errors++; $display("FAIL byte_load_%0d: got %0b/%h want 1/%h", i, wb_valid, wb_data, exp_v[i]); end
    end
  endtask

  task automatic test_stores();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0202, 32'h0000_00AB, 5'd0);
    tick();
    checks++; if (dmem_bus.dmem_addr !== 32'h200 || dmem_bus.dmem_be !== 4'b0010) begin errors++; $display("FAIL sb_addr_be: got %h/%b want 00000200/0010", dmem_bus.dmem_addr, dmem_bus.dmem_be); end
    checks++; if (dmem_bus.dmem_wdata !== 32'hABAB_ABAB || dmem_bus.dmem_we !== 1'b1) begin errors++; $display("FAIL sb_wdata: got %h we %0b want abababab/1", dmem_bus.dmem_wdata, dmem_bus.dmem_we); end
    dmem_bus.dmem_ack = 1'b1;
    tick();
    dmem_bus.dmem_ack = 1'b0;
    clear_inputs();
    checks++; if (wb_valid !== 1'b1 || wb_reg_wr !== 1'b0 || wb_data !== 32'h0) begin errors++; $display("FAIL sb_wb: got %0b/%0b/%h want 1/0/00000000", wb_valid, wb_reg_wr, wb_data); end

    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'h1234_5678, 5'd0);
    tick();
    checks++; if (dmem_bus.dmem_be !== 4'b1111 || dmem_bus.dmem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL sw_be_wdata: got %b/%h want 1111/12345678", dmem_bus.dmem_be, dmem_bus.dmem_wdata); end
    dmem_bus.dmem_ack = 1'b1;
    tick();
    dmem_bus.dmem_ack = 1'b0;
    clear_inputs();

    // Both rd and wr set: treated as a load
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0180, 32'h5555_5555, 5'd12);
    tick();
    checks++; if (dmem_bus.dmem_we !== 1'b0) begin errors++; $display("FAIL rdwr_we: got %0b want 0", dmem_bus.dmem_we); end
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 32'h0BAD_F00D;
    tick();
    dmem_bus.dmem_ack = 1'b0;
    clear_inputs();
    checks++; if (wb_data !== 32'h0BAD_F00D || wb_reg_wr !== 1'b1) begin errors++; $display("FAIL rdwr_wb: got %h/%0b want 0badf00d/1", wb_data, wb_reg_wr); end
  endtask

  task automatic test_misalign();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0206, 32'hCAFE_CAFE, 5'd0);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall: got %0b want 0", stall); end
    tick();
    clear_inputs();
    checks++; if (misalign !== 1'b1 || dmem_bus.dmem_req !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL mis_pulse: got mis %0b req %0b wbv %0b want 1/0/0", misalign, dmem_bus.dmem_req, wb_valid); end
    tick();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_one_cycle: got %0b want 0", misalign); end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'h0, 5'd4);
    tick();
    clear_inputs();
    for (int i = 1; i <= 6; i++) begin
      if (dmem_bus.dmem_req === 1'b1) req_cycles++;
      checks++; if (stall !== (i < 4)) begin errors++; $display("FAIL to_stall: cycle %0d got %0b want %0b", i, stall, (i < 4)); end
      checks++; if (bus_error !== (i == 5)) begin errors++; $display("FAIL to_bus_error: cycle %0d got %0b want %0b", i, bus_error, (i == 5)); end
      tick();
    end
    checks++; if (req_cycles !== 4) begin errors++; $display("FAIL to_req_cycles: got %0d want 4", req_cycles); end
  endtask

  task automatic test_reset_in_req();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0500, 32'h0, 5'd6);
    tick();
    tick();
    reset = 1'b1;
    clear_inputs();
    tick();
    reset = 1'b0;
    checks++; if (dmem_bus.dmem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rr_req: got req %0b stall %0b want 0/0", dmem_bus.dmem_req, stall); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0012, 32'h0, 5'd9);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rr_alu_stall: got %0b want 0", stall); end
    tick();
    clear_inputs();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h12 || wb_dest !== 5'd9) begin errors++; $display("FAIL rr_alu_wb: got %0b/%h/%0d want 1/00000012/9", wb_valid, wb_data, wb_dest); end
  endtask

  initial begin
    reset               = 1'b1;
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
    clear_inputs();
    test_reset();
    test_alu_passthrough();
    test_load_word();
    test_byte_loads();
    test_stores();
    test_misalign();
    test_timeout();
    test_reset_in_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage. Sits directly downstream of Execute.
- Consumes the EX result (address or ALU value) plus the store operand and memory controls.
- Drives a req/ack data-memory port and applies MIPS big-endian byte-lane handling for LW/SW/LB/LBU/SB.
- Delivers a registered writeback bundle. Stalls upstream while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for dmem_ack before the access is aborted.
- CNT_WIDTH, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high reset
- valid_mem  in  1  instruction on the inputs is valid
- alu_result  in  32  EX data_out (effective address or ALU result)
- store_data  in  32  rt operand for stores
- mem_rd  in  1  load
- mem_wr  in  1  store
- mem_byte  in  1  byte access (else word)
- mem_unsigned  in  1  zero-extend byte loads (LBU)
- reg_wr  in  1  instruction writes a register
- dest  in  5  destination register number
- stall  out  1  upstream must hold all inputs this cycle
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address
- dmem_wdata  out  32  write data
- dmem_be  out  4  byte enables; be[3] = MSB lane = byte offset 0
- dmem_ack  in  1  request completed; dmem_rdata valid this cycle
- dmem_rdata  in  32  read data
- wb_valid  out  1  writeback bundle valid (one-cycle pulse per retired instruction)
- wb_data  out  32  writeback value
- wb_dest  out  5  writeback register
- wb_reg_wr  out  1  register write enable
- misalign  out  1  one-cycle pulse: misaligned word access dropped
- bus_error  out  1  one-cycle pulse: access timed out

Behaviour:
- Reset (synchronous): state=IDLE, counter=0. All registered outputs are 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_*, misalign, bus_error. Reset during REQ abandons the access; dmem_req is 0 after that edge.
- States: IDLE, REQ.
- memop = valid_mem & (mem_rd | mem_wr). mem_rd takes precedence if both are set (treated as a load).
- Alignment: misaligned = !mem_byte & (alu_result[1:0] != 0).
- IDLE, valid_mem & !memop: registers wb_data=alu_result, wb_dest=dest, wb_reg_wr=reg_wr, wb_valid=1 at the next edge (latency 1). No stall.
- IDLE, memop & misaligned: no request issued. misalign=1 and wb_valid=0 next cycle. No stall.
- IDLE, memop & aligned: stall=1. At the edge, register:
  - dmem_addr = {alu_result[31:2], 2'b00}
  - dmem_we = mem_wr & !mem_rd
  - dmem_be and dmem_wdata per the lane rules below
  - captured dest/reg_wr/byte/unsigned/offset
  - dmem_req=1, counter=0, go to REQ.
- REQ: dmem_req and all dmem_* outputs are held stable until ack. stall = !dmem_ack (combinational).
- REQ, dmem_ack=1 (ack sampled the same cycle req is high):
  - At the edge: dmem_req=0, state=IDLE, wb_valid=1.
  - Load: wb_data = extracted read data, wb_reg_wr = captured reg_wr.
  - Store: wb_data=0, wb_reg_wr=0.
  - Upstream advances at this same edge (stall low). A new instruction is presented in the following cycle.
- REQ, no ack: counter increments. When counter reaches TIMEOUT_CYCLES-1 without ack: dmem_req=0, bus_error=1, wb_valid=0, state=IDLE; stall is low in that cycle.
- Minimum memory latency: accept in cycle 0, req in cycle 1, ack in cycle 1, wb_valid in cycle 2.
- Word store: be=4'b1111, wdata=store_data.
- Byte store: wdata={4{store_data[7:0]}}, be=4'b1000 >> offset.
- Word load: rdata unchanged.
- Byte load: byte = rdata[31-8*off -: 8]; sign-extended, or zero-extended when the captured unsigned flag is set.
- valid_mem=0 in IDLE: wb_valid=0 next cycle. The other wb_* outputs hold their previous values.
- Inputs are ignored while in REQ. Upstream is required to hold them.

Decomposition:
- control.vh (shared):
  - state encodings MEM_IDLE/MEM_REQ
  - byte-enable constants BE_WORD=4'b1111, BE_BYTE0=4'b1000
  - the mem_rd/mem_wr/mem_byte/mem_unsigned control-bit positions, so Decode/Execute/MEM agree
- One combinational sub-module, load_align: inputs rdata, offset, byte, unsigned; output 32-bit load result. Unit-testable on its own.

Test Plan:
- ADDU result 0x00000007, dest=5, reg_wr=1, valid_mem=1 -> next cycle wb_valid=1, wb_data=0x7, wb_dest=5, wb_reg_wr=1; stall never high.
- LW alu_result=0x00000104, rdata=0xDEADBEEF, ack 3 cycles after req -> dmem_addr=0x104, be=1111, we=0, stall high 4 cycles, wb_data=0xDEADBEEF one cycle after ack.
- LB at 0x103, rdata=0x112233F0 -> wb_data=0xFFFFFFF0. Same as LBU -> 0x000000F0. LB at 0x101 -> 0x00000022.
- SB at 0x202, store_data=0x000000AB -> dmem_addr=0x200, be=0010, wdata=0xABABABAB, we=1; on ack wb_valid=1, wb_reg_wr=0.
- SW at 0x206 -> no dmem_req, misalign pulse one cycle, wb_valid=0, no stall. LW with ack never arriving, TIMEOUT_CYCLES=4 -> req high 4 cycles, bus_error pulse, req drops, stall releases.
- Assert reset in the second cycle of REQ -> dmem_req=0 and state IDLE next cycle. A following ADDU completes normally with latency 1.
